// File: rtl/dmem_responder.sv
// Handshaked data-memory target: one request at a time, fixed LATENCY to the response,
// byte/half/word lane handling. Optional `DMEM_MISALIGN_TRAP_EN rejects misaligned accesses.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              busy
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               cap_ld, commit;

  logic               we_q;
  logic [1:0]         size_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [31:0]        wdata_q;

  logic [31:0]        mem_q [DEPTH_WORDS];
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q;

  logic               op_we;
  logic [1:0]         op_size;
  logic [ADDR_W-1:0]  op_addr;
  logic [31:0]        op_wdata;
  logic [IDX_W-1:0]   op_idx;
  logic               op_oor, op_mis, op_err, mem_wr;
  logic [3:0]         op_be;
  logic [31:0]        op_wplaced;

  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] a);
    logic [3:0] be;
    case (size)
      2'b00:   be = 4'b0001 << a;
      2'b01:   be = a[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicating the narrow datum across the word lets the byte enables pick the lane.
  function automatic logic [31:0] place(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] w;
    case (size)
      2'b00:   w = {4{wdata[7:0]}};
      2'b01:   w = {2{wdata[15:0]}};
      default: w = wdata;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] size,
                                          input logic [1:0] a);
    logic [31:0] r;
    case (size)
      2'b00:   r = {24'b0, word[{a, 3'b000} +: 8]};
      2'b01:   r = a[1] ? {16'b0, word[31:16]} : {16'b0, word[15:0]};
      default: r = word;
    endcase
    return r;
  endfunction

  // With LATENCY == 1 the commit happens on the accept edge, so the live inputs are used.
  always_comb begin
    if (state_q == IDLE) begin
      op_we    = req_we;
      op_size  = req_size;
      op_addr  = req_addr;
      op_wdata = req_wdata;
    end else begin
      op_we    = we_q;
      op_size  = size_q;
      op_addr  = addr_q;
      op_wdata = wdata_q;
    end
  end

  assign op_idx = op_addr[IDX_W+1:2];
  assign op_oor = |(op_addr >> (IDX_W + 2));

`ifdef DMEM_MISALIGN_TRAP_EN
  assign op_mis = ((op_size == 2'b01) && op_addr[0]) ||
                  ((op_size == 2'b10) && (op_addr[1:0] != 2'b00));
`else
  assign op_mis = 1'b0;
`endif

  assign op_err     = op_oor || (op_size == 2'b11) || op_mis;
  assign mem_wr     = commit && op_we && !op_err;
  assign op_be      = lane_be(op_size, op_addr[1:0]);
  assign op_wplaced = place(op_size, op_wdata);
  assign rdata_d    = (op_we || op_err) ? 32'h0 : extract(mem_q[op_idx], op_size, op_addr[1:0]);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap_ld  = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          cap_ld = 1'b1;
          if (LATENCY == 1) begin
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_W'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (commit) begin
        rdata_q <= rdata_d;
        err_q   <= op_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (cap_ld) begin
      we_q    <= req_we;
      size_q  <= req_size;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // Array is deliberately outside the reset domain so committed stores survive reset.
  always_ff @(posedge clk) begin
    if (mem_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (op_be[b]) mem_q[op_idx][8*b +: 8] <= op_wplaced[8*b +: 8];
      end
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign busy       = (state_q != IDLE);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: LATENCY=2 instance for the vector table and backpressure,
// LATENCY=4 instance for reset during WAIT.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_a, rst_b;
  logic        req_valid, req_we, resp_ready;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  int          sel;

  logic        a_req_ready, a_resp_valid, a_resp_err, a_busy;
  logic [31:0] a_resp_rdata;
  logic        b_req_ready, b_resp_valid, b_resp_err, b_busy;
  logic [31:0] b_resp_rdata;
  logic        a_req_valid, b_req_valid;

  logic        m_req_ready, m_resp_valid, m_resp_err, m_busy;
  logic [31:0] m_resp_rdata;

  always #5 clk = ~clk;

  assign a_req_valid  = req_valid && (sel == 0);
  assign b_req_valid  = req_valid && (sel == 1);
  assign m_req_ready  = (sel == 1) ? b_req_ready  : a_req_ready;
  assign m_resp_valid = (sel == 1) ? b_resp_valid : a_resp_valid;
  assign m_resp_err   = (sel == 1) ? b_resp_err   : a_resp_err;
  assign m_busy       = (sel == 1) ? b_busy       : a_busy;
  assign m_resp_rdata = (sel == 1) ? b_resp_rdata : a_resp_rdata;

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2), .ADDR_W(32)) u_dut (
    .clk(clk), .rst(rst_a), .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_we(req_we), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(a_resp_valid), .resp_ready(resp_ready), .resp_rdata(a_resp_rdata),
    .resp_err(a_resp_err), .busy(a_busy)
  );

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(4), .ADDR_W(32)) u_dut4 (
    .clk(clk), .rst(rst_b), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_we(req_we), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(b_resp_valid), .resp_ready(resp_ready), .resp_rdata(b_resp_rdata),
    .resp_err(b_resp_err), .busy(b_busy)
  );

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  localparam int NV = 26;
  vec_t vecs [NV];
  exp_t sb_q [$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic run_req(input logic we, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rdata,
                         input logic exp_err, input int hold, input string name);
    int   guard;
    int   lat;
    int   exp_lat;
    exp_t e;
    exp_lat = (sel == 1) ? 4 : 2;
    guard = 0;
    while (!m_req_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    check({name, " ready before request"}, {31'b0, m_req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_size = size; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    sb_q.push_back('{exp_rdata, exp_err});
    #1 req_valid = 1'b0;
    req_wdata = 32'hFFFF_FFFF;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!m_resp_valid && lat < 20);
    check({name, " latency"}, lat, exp_lat);
    if (m_resp_valid && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({name, " rdata"}, m_resp_rdata, e.rdata);
      check({name, " err"}, {31'b0, m_resp_err}, {31'b0, e.err});
      if (hold > 0) begin
        resp_ready = 1'b0;
        repeat (hold) begin
          @(posedge clk); #1;
          check({name, " held valid"}, {31'b0, m_resp_valid}, 32'd1);
          check({name, " held rdata"}, m_resp_rdata, e.rdata);
          check({name, " held req_ready"}, {31'b0, m_req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
      end
      @(posedge clk); #1;
      check({name, " idle after handshake"}, {30'b0, m_req_ready, m_resp_valid}, 32'b10);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b1, 2'b10, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 2'b10, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 2'b10, 32'h20,  32'h11223344, 32'h0,        1'b0};
    vecs[3]  = '{1'b1, 2'b00, 32'h22,  32'hFFFFFFAA, 32'h0,        1'b0};
    vecs[4]  = '{1'b0, 2'b10, 32'h20,  32'h0,        32'h11AA3344, 1'b0};
    vecs[5]  = '{1'b0, 2'b00, 32'h23,  32'h0,        32'h00000011, 1'b0};
    vecs[6]  = '{1'b0, 2'b01, 32'h22,  32'h0,        32'h000011AA, 1'b0};
    vecs[7]  = '{1'b0, 2'b00, 32'h21,  32'h0,        32'h00000033, 1'b0};
    vecs[8]  = '{1'b0, 2'b01, 32'h20,  32'h0,        32'h00003344, 1'b0};
    vecs[9]  = '{1'b1, 2'b10, 32'h00,  32'hA5A5A5A5, 32'h0,        1'b0};
    vecs[10] = '{1'b1, 2'b00, 32'h400, 32'h00000055, 32'h0,        1'b1};
    vecs[11] = '{1'b0, 2'b11, 32'h00,  32'h0,        32'h0,        1'b1};
    vecs[12] = '{1'b0, 2'b10, 32'h00,  32'h0,        32'hA5A5A5A5, 1'b0};
    vecs[13] = '{1'b1, 2'b11, 32'h10,  32'h0,        32'h0,        1'b1};
    vecs[14] = '{1'b0, 2'b10, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
    vecs[15] = '{1'b1, 2'b01, 32'h32,  32'hFFFFBEEF, 32'h0,        1'b0};
    vecs[16] = '{1'b1, 2'b01, 32'h30,  32'h00001234, 32'h0,        1'b0};
    vecs[17] = '{1'b0, 2'b10, 32'h30,  32'h0,        32'hBEEF1234, 1'b0};
    vecs[18] = '{1'b0, 2'b10, 32'h80000010, 32'h0,   32'h0,        1'b1};
    vecs[19] = '{1'b1, 2'b10, 32'h04,  32'h0BADF00D, 32'h0,        1'b0};
`ifdef DMEM_MISALIGN_TRAP_EN
    vecs[20] = '{1'b0, 2'b10, 32'h06,  32'h0,        32'h0,        1'b1};
    vecs[21] = '{1'b0, 2'b01, 32'h05,  32'h0,        32'h0,        1'b1};
    vecs[22] = '{1'b1, 2'b01, 32'h07,  32'h0000CAFE, 32'h0,        1'b1};
    vecs[23] = '{1'b0, 2'b10, 32'h04,  32'h0,        32'h0BADF00D, 1'b0};
`else
    vecs[20] = '{1'b0, 2'b10, 32'h06,  32'h0,        32'h0BADF00D, 1'b0};
    vecs[21] = '{1'b0, 2'b01, 32'h05,  32'h0,        32'h0000F00D, 1'b0};
    vecs[22] = '{1'b1, 2'b01, 32'h07,  32'h0000CAFE, 32'h0,        1'b0};
    vecs[23] = '{1'b0, 2'b10, 32'h04,  32'h0,        32'hCAFEF00D, 1'b0};
`endif
    vecs[24] = '{1'b1, 2'b10, 32'h3FC, 32'h13579BDF, 32'h0,        1'b0};
    vecs[25] = '{1'b0, 2'b00, 32'h3FF, 32'h0,        32'h00000013, 1'b0};

    sel = 0;
    rst_a = 1'b0; rst_b = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h0; req_wdata = 32'h0;
    resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset req_ready", {31'b0, a_req_ready}, 32'd1);
    check("reset resp_valid", {31'b0, a_resp_valid}, 32'd0);
    check("reset resp_rdata", a_resp_rdata, 32'h0);
    check("reset resp_err", {31'b0, a_resp_err}, 32'd0);
    check("reset busy", {31'b0, a_busy}, 32'd0);
    rst_a = 1'b1; rst_b = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      run_req(vecs[i].we, vecs[i].size, vecs[i].addr, vecs[i].wdata,
              vecs[i].exp_rdata, vecs[i].exp_err, 0, $sformatf("vec%0d", i));
    end

    run_req(1'b0, 2'b10, 32'h20, 32'h0, 32'h11AA3344, 1'b0, 5, "backpressure");

    sel = 1;
    run_req(1'b1, 2'b10, 32'h08, 32'hCAFEF00D, 32'h0, 1'b0, 0, "lat4 store");
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h08; req_wdata = 32'h12345678;
    @(posedge clk);
    #1 req_valid = 1'b0;
    check("lat4 busy in WAIT", {31'b0, m_busy}, 32'd1);
    @(posedge clk);
    #1 rst_b = 1'b0;
    #1;
    check("mid-WAIT reset resp_valid", {31'b0, m_resp_valid}, 32'd0);
    check("mid-WAIT reset req_ready", {31'b0, m_req_ready}, 32'd1);
    check("mid-WAIT reset busy", {31'b0, m_busy}, 32'd0);
    @(posedge clk);
    #1 rst_b = 1'b1;
    @(posedge clk); #1;
    run_req(1'b0, 2'b10, 32'h08, 32'h0, 32'hCAFEF00D, 1'b0, 0, "lat4 load after reset");

    check("scoreboard drained", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Handshaked data-memory target serving the core's load/store port. It is the responder end of the processor's data access path.
- Accepts one request at a time: address, write enable, size and right-aligned write data.
- Performs byte-lane placement for stores and lane extraction for loads.
- Returns a response after a fixed, parameterised latency. Lets the memory side model multi-cycle SRAM or bus behaviour in place of the zero-latency array.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words in the array; power of two, at least 4.
- LATENCY, 2, cycles from the request-accept edge to resp_valid high; at least 1.
- ADDR_W, 32, width of req_addr.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-low (0 = reset).
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid  out  1  response present.
- resp_ready  in  1  requester accepts the response.
- resp_rdata  out  32  load data, right-aligned, zero-extended; sign extension stays in the core.
- resp_err  out  1  request rejected; no memory side effect.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- FSM states: IDLE, WAIT, RESP.
- Reset values: state IDLE, req_ready 1, resp_valid 0, resp_rdata 0, resp_err 0, busy 0, latency counter 0. Array contents are not cleared by reset.
- IDLE:
  - req_ready is 1.
  - On req_valid & req_ready, capture we/size/addr/wdata.
  - Go to WAIT with counter = LATENCY-1, or straight to RESP when LATENCY = 1.
- WAIT:
  - req_ready is 0.
  - Counter decrements each cycle; at 0, move to RESP on the next edge.
  - Request inputs are ignored.
- Commit point: on the edge that enters RESP:
  - Store: write the enabled byte lanes.
  - Load: register the extracted data.
  - resp_valid therefore rises exactly LATENCY cycles after the accept edge.
- RESP:
  - resp_valid is 1; resp_rdata and resp_err are held stable until resp_ready.
  - On resp_valid & resp_ready, go to IDLE and clear resp_valid.
  - A new request cannot be accepted before the following cycle, so there are no back-to-back transfers.
- Stores always produce a response, with resp_rdata = 0.
- Word index is addr[log2(DEPTH_WORDS)+1:2]. Lane is addr[1:0] for byte accesses and addr[1] for half accesses.
- Store lane placement:
  - byte: wdata[7:0] into lane addr[1:0].
  - half: wdata[15:0] into the half selected by addr[1].
  - word: all four lanes.
- Load extraction:
  - byte: selected lane placed in [7:0], upper bits 0.
  - half: selected half placed in [15:0], upper bits 0.
  - word: full word.
- Error cases (resp_err = 1, no write, resp_rdata = 0, timing unchanged):
  - any req_addr bit at or above log2(DEPTH_WORDS)+2 is set (out of range);
  - req_size = 11.
- Misalignment without the optional feature: address bits below the access size are ignored (half uses addr[1], word ignores addr[1:0]).
- Reset while in WAIT or RESP: returns immediately to IDLE. An uncommitted store is dropped; a store already committed remains in the array.
- resp_ready asserted outside RESP has no effect.

Optional Feature:
- Macro: DMEM_MISALIGN_TRAP_EN.
- Defined: a half access with addr[0] = 1, or a word access with addr[1:0] ≠ 00, completes with resp_err = 1, no write and resp_rdata = 0, keeping normal latency.
- Undefined: misaligned low address bits are silently ignored as described in Behaviour.

Test Plan:
- Word store then load, LATENCY = 2:
  - Stimulus: store 0xDEADBEEF to 0x10, then load 0x10.
  - Response: each resp_valid rises 2 cycles after its accept edge; load resp_rdata = 0xDEADBEEF, resp_err = 0.
- Byte lanes:
  - Stimulus: word 0x11223344 at 0x20, then byte store 0xAA to 0x22.
  - Response: word load of 0x20 returns 0x11AA3344; byte load of 0x23 returns 0x00000011; half load of 0x22 returns 0x000011AA.
- Backpressure:
  - Stimulus: hold resp_ready = 0 for 5 cycles in RESP.
  - Response: resp_valid and resp_rdata stay stable, req_ready stays 0; after resp_ready = 1 for one cycle, IDLE with req_ready = 1 next cycle.
- Errors:
  - Stimulus: store 0x55 to address 0x400 with DEPTH_WORDS = 256; then a req_size = 11 load.
  - Response: both give resp_err = 1; a later word load of 0x000 is unaffected.
- Reset mid-WAIT:
  - Stimulus: LATENCY = 4, store 0x12345678 to 0x08, drop rst one cycle after accept.
  - Response: immediately resp_valid = 0 and req_ready = 1; a later load of 0x08 returns the prior contents.
- DMEM_MISALIGN_TRAP_EN:
  - Stimulus: word load of 0x06.
  - Response: defined → resp_err = 1, resp_rdata = 0; undefined → data of word 0x04, resp_err = 0.
